// File: rtl/univ_reg_seq_pkg.sv
// Shared definitions for the universal register / auto-repeat sequencer.
//   - MODE_* : operation select encodings for the 3-bit mode input.
//   - state_e: sequencer FSM state encoding.
//   - is_seq_mode(): true for modes that the sequencer may repeat.
package univ_reg_seq_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // HOLD and LOAD are not repeatable; everything from SHL upwards is.
    function automatic logic is_seq_mode(input logic [2:0] m);
        return m[2] | m[1];
    endfunction

endpackage

// File: rtl/univ_reg_alu.sv
// Combinational next-value logic of the universal register.
// Ports:
//   mode      - operation select (see univ_reg_seq_pkg MODE_*)
//   A         - current register contents
//   I         - parallel load data
//   sin_l     - serial bit entering the LSB on shift-left
//   sin_r     - serial bit entering the MSB on shift-right
//   next_A    - register value after the operation
//   next_cout - shifted/rotated-out bit, carry or borrow (0 for HOLD/LOAD)
module univ_reg_alu
    import univ_reg_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] I,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] next_A,
    output logic             next_cout
);

    // One extra bit on the adder exposes carry (INC) and borrow (DEC) directly.
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    assign inc_w = {1'b0, A} + (WIDTH+1)'(1);
    assign dec_w = {1'b0, A} - (WIDTH+1)'(1);

    always_comb begin
        next_A    = A;
        next_cout = 1'b0;
        case (mode)
            MODE_HOLD: begin
                next_A    = A;
                next_cout = 1'b0;
            end
            MODE_LOAD: begin
                next_A    = I;
                next_cout = 1'b0;
            end
            MODE_SHL: begin
                next_A    = {A[WIDTH-2:0], sin_l};
                next_cout = A[WIDTH-1];
            end
            MODE_SHR: begin
                next_A    = {sin_r, A[WIDTH-1:1]};
                next_cout = A[0];
            end
            MODE_ROTL: begin
                next_A    = {A[WIDTH-2:0], A[WIDTH-1]};
                next_cout = A[WIDTH-1];
            end
            MODE_ROTR: begin
                next_A    = {A[0], A[WIDTH-1:1]};
                next_cout = A[0];
            end
            MODE_INC: begin
                next_A    = inc_w[WIDTH-1:0];
                next_cout = inc_w[WIDTH];
            end
            MODE_DEC: begin
                next_A    = dec_w[WIDTH-1:0];
                next_cout = dec_w[WIDTH];
            end
            default: begin
                next_A    = A;
                next_cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_reg_seq.sv
// Universal register with an auto-repeat sequencer.
// Executes HOLD/LOAD/SHL/SHR/ROTL/ROTR/INC/DEC every clock, or, on start,
// repeats a latched operation cnt times with a busy/done handshake.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   mode  - operation select
//   I     - parallel load data
//   sin_l - serial input for shift-left (enters LSB), sampled live in RUN
//   sin_r - serial input for shift-right (enters MSB), sampled live in RUN
//   start - request auto-repeat of mode, cnt times
//   cnt   - repeat count
//   A     - register contents
//   cout  - shifted/rotated-out bit, carry or borrow
//   busy  - sequencer running
//   done  - one-cycle pulse at sequence end
module univ_reg_seq
    import univ_reg_seq_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] I,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] A,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] rem_q;

    logic [2:0]       alu_mode;
    logic [WIDTH-1:0] alu_a;
    logic             alu_cout;

    // While running, the latched operation replaces the live mode input.
    assign alu_mode = (state_q == ST_RUN) ? op_q : mode;

    univ_reg_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .mode      (alu_mode),
        .A         (a_q),
        .I         (I),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .next_A    (alu_a),
        .next_cout (alu_cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= RST_VAL;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= MODE_HOLD;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && is_seq_mode(mode)) begin
                        // Accepting edge leaves A and cout untouched.
                        if (cnt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            op_q    <= mode;
                            rem_q   <= cnt;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        a_q    <= alu_a;
                        cout_q <= alu_cout;
                    end
                end
                ST_RUN: begin
                    a_q    <= alu_a;
                    cout_q <= alu_cout;
                    rem_q  <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A    = a_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/univ_reg_seq.md
Name: univ_reg_seq

Overview:
Parametrised universal register with an auto-repeat sequencer. Supports hold, parallel load, shift, rotate and increment/decrement of a WIDTH-bit word. It can also repeat a chosen operation N times on its own, with busy/done handshake. Serves as the general register/counter datapath element, a generalised successor of the 4-bit parallel-load register.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- RST_VAL, 0, value of A after reset.
- CNT_W (localparam), $clog2(WIDTH+1), width of repeat count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-low (0 = reset).
- mode  in  3  operation select (encoding below).
- I  in  WIDTH  parallel load data.
- sin_l  in  1  serial input for shift-left; enters the LSB.
- sin_r  in  1  serial input for shift-right; enters the MSB.
- start  in  1  request auto-repeat of mode, cnt times.
- cnt  in  CNT_W  repeat count.
- A  out  WIDTH  register contents.
- cout  out  1  bit shifted or rotated out, or carry/borrow.
- busy  out  1  sequencer running.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Mode encoding:
  - 000 HOLD, 001 LOAD (A<=I).
  - 010 SHL (A<={A[W-2:0],sin_l}), 011 SHR (A<={sin_r,A[W-1:1]}).
  - 100 ROTL, 101 ROTR.
  - 110 INC, 111 DEC, both modulo 2^WIDTH.
- Reset (rst=0, async): A=RST_VAL, cout=0, busy=0, done=0, FSM=IDLE. Takes effect immediately, including mid-sequence.
- All outputs are registered; an operation sampled at edge k is visible after edge k.
- cout:
  - SHL: old A[W-1]. SHR: old A[0].
  - ROTL/ROTR: the wrapped bit.
  - INC: 1 iff old A all ones. DEC: 1 iff old A = 0.
  - HOLD/LOAD: 0.
  - cout updates together with A.
- FSM states:
  - IDLE:
    - start=0: the mode on the inputs executes every edge.
    - start=1, mode in {SHL..DEC}, cnt>0: latch mode and cnt, go to RUN, busy=1 after this edge. A is not modified on this edge.
    - start=1, cnt=0: A unchanged, done=1 for one cycle, busy stays 0.
    - start=1, mode HOLD/LOAD: start is ignored and the mode executes normally.
  - RUN: one latched operation per edge; remaining count decrements. On the edge that executes the last operation: go to IDLE, busy=0, done=1. done clears on the following edge.
- During RUN:
  - mode, I, cnt and start are ignored.
  - sin_l and sin_r are sampled live every cycle, so a serial stream can be fed in.
- Latency: start sampled at edge 0; operations occur at edges 1..cnt; A is final and done=1 after edge cnt.
- A new start is accepted in the cycle done=1, since the FSM is already IDLE.
- No abort other than reset. Reset mid-run means done never pulses for that sequence.

Decomposition:
- Shared package:
  - mode localparams MODE_HOLD..MODE_DEC.
  - FSM state encoding ST_IDLE, ST_RUN.
- Sub-module univ_reg_alu (combinational): inputs mode, A, I, sin_l, sin_r; outputs next_A, next_cout.
- The top level holds the register, the FSM and the down-counter.

Test Plan:
1. Reset and hold: rst=0 at t=0 -> A=0000, busy=0, done=0; release rst, mode=HOLD for 3 cycles -> A stays 0000.
2. Load and shift (WIDTH=4):
   - LOAD I=1010 -> A=1010.
   - SHR with sin_r=1 -> A=1101, cout=0.
   - SHL with sin_l=0 -> A=1010, cout=1.
3. Inc/dec wrap:
   - LOAD 1111 then INC -> A=0000, cout=1.
   - DEC -> A=1111, cout=1.
   - DEC -> A=1110, cout=0.
4. Sequence:
   - LOAD 0011; start, mode=ROTL, cnt=3 -> busy=1 for 3 cycles.
   - A steps 0110, 1100, 1001; done=1 for exactly one cycle with A=1001.
   - mode=LOAD and I=0000 driven during busy -> no effect.
5. Reset mid-run: A=1110, start INC cnt=5; after 2 ops (A=0000) pull rst=0 -> A=0000 immediately, busy=0; done never pulses; after release, FSM is IDLE.
6. Edge cases:
   - start with cnt=0 -> done=1 one cycle, A unchanged, busy=0.
   - start with mode=LOAD, I=0101 -> A=0101, busy stays 0, no done.
